alarm_arm_controller: RTL
=========================

Name: alarm_arm_controller

Overview:
Keypad-driven arming sequencer for the security alarm path. It accepts PIN digits, arms and disarms the system, and times the exit delay, entry delay and siren phases. It also enforces a lockout after repeated bad PINs. Its outputs drive the alarm state pins and the siren enable.

Parameters:
PIN_LEN, 4, number of BCD digits in a PIN entry
PIN, 16'h1234, fixed PIN; first digit entered = most significant nibble
EXIT_DLY, 16, cycles spent in EXIT_DELAY (>=1)
ENTRY_DLY, 8, cycles spent in ENTRY_DELAY (>=1)
SIREN_CYC, 32, cycles spent in ALARM before auto re-arm (>=1)
MAX_TRIES, 3, consecutive bad PINs that trigger lockout
LOCK_CYC, 64, lockout duration in cycles
CNT_W, 8, width of the phase timer and lockout timer; all delay parameters must be <= 2^CNT_W

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
key_valid  in  1  one-cycle strobe: key_digit is valid
key_digit  in  4  BCD digit 0-9; values 10-15 count as digits and can never match PIN
key_clear  in  1  discard the partial entry
sensor  in  1  intrusion sensor, level, active high
state  out  3  current state encoding (package)
armed  out  1  high in ARMED, ENTRY_DELAY, ALARM
siren  out  1  high in ALARM only
warn  out  1  high in EXIT_DELAY or ENTRY_DELAY (buzzer)
pin_ok  out  1  one-cycle pulse: correct PIN accepted
pin_bad  out  1  one-cycle pulse: wrong PIN
locked  out  1  keypad lockout active
tries  out  2  consecutive bad-PIN count

Behaviour:
- Reset (async): state=DISARMED; all outputs 0; digit buffer and count cleared; timers 0.
- Digit entry:
  - key_valid with locked=0 shifts key_digit into the buffer and increments the count.
  - key_clear clears the buffer and count. It takes priority over key_valid in the same cycle.
  - While locked=1, key_valid and key_clear are ignored.
- PIN compare:
  - The cycle after the PIN_LEN-th digit is accepted, pin_ok or pin_bad pulses for exactly 1 cycle. The buffer clears in the same cycle.
  - The state transition caused by pin_ok is visible on state one cycle after the pin_ok pulse.
- Bad-PIN counting:
  - pin_bad increments tries.
  - When tries reaches MAX_TRIES: tries goes to 0 and locked=1 for exactly LOCK_CYC cycles.
  - pin_ok resets tries to 0.
  - Lockout never changes the main state.
- Phase timer:
  - Entering a timed state loads N-1, then decrements each cycle. The state exits when the timer is 0, so it lasts exactly N cycles.
- Transitions (pin_ok has priority over sensor and over timer expiry in the same cycle):
  - DISARMED: pin_ok -> EXIT_DELAY.
  - EXIT_DELAY: pin_ok -> DISARMED; timer==0 -> ARMED; sensor ignored.
  - ARMED: pin_ok -> DISARMED; sensor=1 -> ENTRY_DELAY.
  - ENTRY_DELAY: pin_ok -> DISARMED; timer==0 -> ALARM.
  - ALARM: pin_ok -> DISARMED; timer==0 -> ARMED. On re-arm, a sensor still high re-enters ENTRY_DELAY the next cycle.
- Illegal state encoding -> DISARMED next cycle.
- Reset mid-operation (including during lockout or ALARM) returns everything to reset values immediately.

Decomposition:
- Package alarm_pkg:
  - state encoding: DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4
  - digit width constant (4)
- Sub-module pin_checker:
  - contents: digit buffer, count, compare, tries counter, lockout timer
  - outputs: pin_ok, pin_bad, locked, tries
- The top level holds the state machine and the phase timer.

Test Plan:
- Arm path: reset, keys 1,2,3,4 -> pin_ok pulse 1 cycle after the 4th key; state=EXIT_DELAY next cycle; warn=1 for 16 cycles; then state=ARMED, armed=1.
- Intrusion: ARMED, sensor=1 for 1 cycle -> ENTRY_DELAY for 8 cycles, then ALARM with siren=1 for 32 cycles, then ARMED with siren=0.
- Disarm race: in ENTRY_DELAY, align the pin_ok cycle with timer==0 -> state=DISARMED, never ALARM; siren stays 0.
- Lockout: three entries of 9,9,9,9 -> pin_bad x3, tries=1,2 then 0; locked=1 for 64 cycles. Keys 1,2,3,4 during lockout -> no pin_ok. After lockout, 1,2,3,4 -> pin_ok.
- Clear handling: keys 1,2, then key_clear and key_valid(5) in the same cycle, then 1,2,3,4 -> exactly one pin_ok, no pin_bad.
- Async reset: assert rst_n=0 mid-ALARM off a clock edge -> siren=0 and state=DISARMED immediately; locked=0, tries=0.

Source files
------------

// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alarm_pkg
// Description : Shared state encoding and constants for the alarm arming
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alarm_pkg;

    // Main alarm state encoding, also presented on the state output pins.
    typedef enum logic [2:0] {
        ST_DISARMED    = 3'd0,
        ST_EXIT_DELAY  = 3'd1,
        ST_ARMED       = 3'd2,
        ST_ENTRY_DELAY = 3'd3,
        ST_ALARM       = 3'd4
    } alarm_state_e;

    // Width of one keypad digit.
    localparam int unsigned DIGIT_W = 4;

endpackage : alarm_pkg
`default_nettype wire

// File: rtl/alarm_arm_controller_pin_checker.sv
`default_nettype none
// ============================================================================
// Module      : alarm_arm_controller_pin_checker
// Description : Collects keypad digits, compares a complete entry against the
//               fixed PIN, counts consecutive bad entries and times the
//               keypad lockout.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_arm_controller_pin_checker
    import alarm_pkg::*;
#(
    parameter int unsigned                 PIN_LEN   = 4,
    parameter logic [DIGIT_W*PIN_LEN-1:0]  PIN       = 16'h1234,
    parameter int unsigned                 MAX_TRIES = 3,
    parameter int unsigned                 LOCK_CYC  = 64,
    parameter int unsigned                 CNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_key_valid,
    input  logic [DIGIT_W-1:0]  i_key_digit,
    input  logic                i_key_clear,
    output logic                o_pin_ok,
    output logic                o_pin_bad,
    output logic                o_locked,
    output logic [1:0]          o_tries
);

    localparam int unsigned C_BUF_W = DIGIT_W * PIN_LEN;
    localparam int unsigned C_CNT_W = $clog2(PIN_LEN + 1);

    logic [C_BUF_W-1:0]  r_buf;
    logic [C_CNT_W-1:0]  r_cnt;
    logic                r_ok;
    logic                r_bad;
    logic                r_locked;
    logic [CNT_W-1:0]    r_lock_cnt;
    logic [1:0]          r_tries;
    logic [C_BUF_W-1:0]  w_shifted;
    logic                w_last_digit;

    // Entry as it would look with the current key appended (first digit ends
    // up in the most significant nibble).
    assign w_shifted    = {r_buf[C_BUF_W-DIGIT_W-1:0], i_key_digit};
    assign w_last_digit = (r_cnt == C_CNT_W'(PIN_LEN - 1));

    // Digit buffer and compare; the verdict pulse follows the final digit and
    // the buffer empties on the same edge. Keys are ignored while locked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf <= '0;
            r_cnt <= '0;
            r_ok  <= 1'b0;
            r_bad <= 1'b0;
        end else begin
            r_ok  <= 1'b0;
            r_bad <= 1'b0;
            if (!r_locked) begin
                if (i_key_clear) begin
                    r_buf <= '0;
                    r_cnt <= '0;
                end else if (i_key_valid) begin
                    if (w_last_digit) begin
                        r_buf <= '0;
                        r_cnt <= '0;
                        r_ok  <= (w_shifted == PIN);
                        r_bad <= (w_shifted != PIN);
                    end else begin
                        r_buf <= w_shifted;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Bad-entry counter and lockout timer; the final allowed miss resets the
    // count and holds the keypad off for LOCK_CYC cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tries    <= 2'd0;
            r_locked   <= 1'b0;
            r_lock_cnt <= '0;
        end else begin
            if (r_locked) begin
                if (r_lock_cnt == '0) begin
                    r_locked <= 1'b0;
                end else begin
                    r_lock_cnt <= r_lock_cnt - 1'b1;
                end
            end
            if (r_ok) begin
                r_tries <= 2'd0;
            end else if (r_bad) begin
                if (r_tries == 2'(MAX_TRIES - 1)) begin
                    r_tries    <= 2'd0;
                    r_locked   <= 1'b1;
                    r_lock_cnt <= CNT_W'(LOCK_CYC - 1);
                end else begin
                    r_tries <= r_tries + 2'd1;
                end
            end
        end
    end

    assign o_pin_ok  = r_ok;
    assign o_pin_bad = r_bad;
    assign o_locked  = r_locked;
    assign o_tries   = r_tries;

endmodule : alarm_arm_controller_pin_checker
`default_nettype wire

// File: rtl/alarm_arm_controller.sv
`default_nettype none
// ============================================================================
// Module      : alarm_arm_controller
// Description : Keypad-driven arming sequencer. Holds the main alarm state
//               machine and the phase timer for exit delay, entry delay and
//               siren phases; PIN handling lives in the pin checker.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_arm_controller
    import alarm_pkg::*;
#(
    parameter int unsigned                 PIN_LEN   = 4,
    parameter logic [DIGIT_W*PIN_LEN-1:0]  PIN       = 16'h1234,
    parameter int unsigned                 EXIT_DLY  = 16,
    parameter int unsigned                 ENTRY_DLY = 8,
    parameter int unsigned                 SIREN_CYC = 32,
    parameter int unsigned                 MAX_TRIES = 3,
    parameter int unsigned                 LOCK_CYC  = 64,
    parameter int unsigned                 CNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_key_valid,
    input  logic [DIGIT_W-1:0]  i_key_digit,
    input  logic                i_key_clear,
    input  logic                i_sensor,
    output logic [2:0]          o_state,
    output logic                o_armed,
    output logic                o_siren,
    output logic                o_warn,
    output logic                o_pin_ok,
    output logic                o_pin_bad,
    output logic                o_locked,
    output logic [1:0]          o_tries
);

    alarm_state_e       r_state;
    alarm_state_e       w_state_next;
    logic [CNT_W-1:0]   r_timer;
    logic [CNT_W-1:0]   w_timer_next;
    logic               w_pin_ok;
    logic               w_tmr_zero;

    alarm_arm_controller_pin_checker #(
        .PIN_LEN   (PIN_LEN),
        .PIN       (PIN),
        .MAX_TRIES (MAX_TRIES),
        .LOCK_CYC  (LOCK_CYC),
        .CNT_W     (CNT_W)
    ) u_pin_checker (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_key_valid (i_key_valid),
        .i_key_digit (i_key_digit),
        .i_key_clear (i_key_clear),
        .o_pin_ok    (w_pin_ok),
        .o_pin_bad   (o_pin_bad),
        .o_locked    (o_locked),
        .o_tries     (o_tries)
    );

    assign w_tmr_zero = (r_timer == '0);

    // State and phase-timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_DISARMED;
            r_timer <= '0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
        end
    end

    // Next-state decode (a correct PIN beats sensor and timer expiry) and
    // timer reload on entry to a timed phase so it lasts exactly N cycles.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = w_tmr_zero ? '0 : (r_timer - 1'b1);
        case (r_state)
            ST_DISARMED: begin
                if (w_pin_ok) w_state_next = ST_EXIT_DELAY;
            end
            ST_EXIT_DELAY: begin
                if (w_pin_ok)        w_state_next = ST_DISARMED;
                else if (w_tmr_zero) w_state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (w_pin_ok)      w_state_next = ST_DISARMED;
                else if (i_sensor) w_state_next = ST_ENTRY_DELAY;
            end
            ST_ENTRY_DELAY: begin
                if (w_pin_ok)        w_state_next = ST_DISARMED;
                else if (w_tmr_zero) w_state_next = ST_ALARM;
            end
            ST_ALARM: begin
                if (w_pin_ok)        w_state_next = ST_DISARMED;
                else if (w_tmr_zero) w_state_next = ST_ARMED;
            end
            default: begin
                w_state_next = ST_DISARMED;
            end
        endcase
        if (w_state_next != r_state) begin
            case (w_state_next)
                ST_EXIT_DELAY:  w_timer_next = CNT_W'(EXIT_DLY - 1);
                ST_ENTRY_DELAY: w_timer_next = CNT_W'(ENTRY_DLY - 1);
                ST_ALARM:       w_timer_next = CNT_W'(SIREN_CYC - 1);
                default:        w_timer_next = '0;
            endcase
        end
    end

    assign o_state  = r_state;
    assign o_armed  = (r_state == ST_ARMED) || (r_state == ST_ENTRY_DELAY) ||
                      (r_state == ST_ALARM);
    assign o_siren  = (r_state == ST_ALARM);
    assign o_warn   = (r_state == ST_EXIT_DELAY) || (r_state == ST_ENTRY_DELAY);
    assign o_pin_ok = w_pin_ok;

endmodule : alarm_arm_controller
`default_nettype wire
